nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer_if.sv | 38 +++
 rtl/nibble_packer.sv | 191 +++++++++++++++++++
 tb/tb_nibble_packer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_packer_if.sv
// nibble_packer_if
//   Bundles the upstream FIFO pop handshake and the downstream packed-word
//   handshake of the nibble packer into one interface.
//   Parameters: WIDTH (bits per lane), LANES (lanes per word), L2L (log2 LANES).
//   Signals:
//     fifo_pop_req  packer -> FIFO   pop request
//     fifo_pop_ack  FIFO -> packer   pop acknowledge (handshake = req && ack)
//     fifo_data     FIFO -> packer   read data, valid the cycle after a handshake
//     fifo_empty    FIFO -> packer   empty flag (only used by the flush timer)
//     out_data      packer -> sink   packed word, lane 0 in the LSBs
//     out_valid     packer -> sink   out_data/out_count valid
//     out_ready     sink -> packer   word accepted when valid && ready
//     out_count     packer -> sink   number of valid lanes, 1..LANES
//   Modports: master = packer side, slave = environment side.
interface nibble_packer_if #(
  parameter int WIDTH = 4,
  parameter int LANES = 4,
  parameter int L2L   = 2
);
  logic                   fifo_pop_req;
  logic                   fifo_pop_ack;
  logic [WIDTH-1:0]       fifo_data;
  logic                   fifo_empty;
  logic [WIDTH*LANES-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [L2L:0]           out_count;

  modport master (
    output fifo_pop_req, out_data, out_valid, out_count,
    input  fifo_pop_ack, fifo_data, fifo_empty, out_ready
  );

  modport slave (
    input  fifo_pop_req, out_data, out_valid, out_count,
    output fifo_pop_ack, fifo_data, fifo_empty, out_ready
  );
endinterface

// File: rtl/nibble_packer.sv
// nibble_packer
//   Pops WIDTH-bit entries one at a time from an upstream FIFO and packs
//   LANES of them into one output word (lane 0 in the LSBs, filled first).
//   A three-state FSM (POP -> CAP -> ... -> SEND) keeps at most one pop
//   outstanding; the word is held stable in SEND until the sink takes it.
//   Ports:
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset; discards any partial or pending word
//     bus     nibble_packer_if.master (FIFO pop handshake + packed-word handshake)
//   Optional feature (macro PACKER_FLUSH_EN): a partial word is flushed after
//   FLUSH_CYCLES consecutive empty cycles, with out_count giving the lane
//   count. Without the macro partial words wait and out_count is LANES.
module nibble_packer #(
  parameter int WIDTH        = 4,
  parameter int LANES        = 4,
  parameter int L2L          = 2,
  parameter int FLUSH_CYCLES = 7
) (
  input  logic            clk,
  input  logic            resetn,
  nibble_packer_if.master bus
);

  typedef enum logic [1:0] {
    ST_POP  = 2'd0,
    ST_CAP  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [L2L:0]           CNT_ZERO  = {(L2L+1){1'b0}};
  localparam logic [L2L:0]           CNT_ONE   = {{L2L{1'b0}}, 1'b1};
  localparam logic [L2L:0]           LAST_LANE = (L2L+1)'(LANES - 1);
  localparam logic [L2L:0]           FULL_CNT  = (L2L+1)'(LANES);
  localparam logic [WIDTH*LANES-1:0] DATA_ZERO = {(WIDTH*LANES){1'b0}};

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [L2L:0]           cnt_r;
  logic [WIDTH*LANES-1:0] lanes_r;
  logic                   pop_req_r;
  logic                   out_valid_r;
  logic [L2L:0]           out_count_r;
  logic                   pop_hs_s;
  logic                   flush_s;

  assign pop_hs_s = pop_req_r & bus.fifo_pop_ack;

`ifdef PACKER_FLUSH_EN
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] FLUSH_MAX  = 8'(FLUSH_CYCLES);

  logic [7:0] timer_r;
  logic       timer_run_s;

  // Empty cycles count only while a partial word waits for its next entry;
  // the flush fires on the FLUSH_CYCLES-th such cycle unless a pop lands.
  always_comb begin
    timer_run_s = (state_r == ST_POP) && (cnt_r != CNT_ZERO) &&
                  bus.fifo_empty && !pop_hs_s;
    flush_s     = timer_run_s && (timer_r == FLUSH_LAST);
  end

  // Saturating count of consecutive empty cycles, cleared by anything else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r <= 8'd0;
    end else if (!timer_run_s) begin
      timer_r <= 8'd0;
    end else if (timer_r != FLUSH_MAX) begin
      timer_r <= timer_r + 8'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Lane count latched on entry to SEND: full word from CAP, partial from a flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_count_r <= CNT_ZERO;
    end else if ((state_r == ST_CAP) && (state_nxt_s == ST_SEND)) begin
      out_count_r <= FULL_CNT;
    end else if ((state_r == ST_POP) && (state_nxt_s == ST_SEND)) begin
      out_count_r <= cnt_r;
    end else begin
      out_count_r <= out_count_r;
    end
  end
`else
  logic [8:0] unused_flush_s;

  assign flush_s        = 1'b0;
  assign unused_flush_s = {bus.fifo_empty, 8'(FLUSH_CYCLES)};

  // Only full words are ever emitted; the count reads 0 only while in reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_count_r <= CNT_ZERO;
    end else begin
      out_count_r <= FULL_CNT;
    end
  end
`endif

  // Next-state logic; a pop handshake outranks a flush in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_POP: begin
        if (pop_hs_s) begin
          state_nxt_s = ST_CAP;
        end else if (flush_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_POP;
        end
      end
      ST_CAP: begin
        if (cnt_r == LAST_LANE) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_POP;
        end
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_POP;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s = ST_POP;
      end
    endcase
  end

  // State register; req/valid are registered from the next state so they are
  // low in reset, req first rises on the edge after release, and valid never
  // follows out_ready combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_POP;
      pop_req_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pop_req_r   <= (state_nxt_s == ST_POP);
      out_valid_r <= (state_nxt_s == ST_SEND);
    end
  end

  // Datapath: one lane captured per CAP cycle, word cleared once accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r   <= CNT_ZERO;
      lanes_r <= DATA_ZERO;
    end else begin
      case (state_r)
        ST_CAP: begin
          for (int i = 0; i < LANES; i++) begin
            if (cnt_r == (L2L+1)'(i)) begin
              lanes_r[i*WIDTH +: WIDTH] <= bus.fifo_data;
            end else begin
              lanes_r[i*WIDTH +: WIDTH] <= lanes_r[i*WIDTH +: WIDTH];
            end
          end
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_SEND: begin
          if (bus.out_ready) begin
            cnt_r   <= CNT_ZERO;
            lanes_r <= DATA_ZERO;
          end else begin
            cnt_r   <= cnt_r;
            lanes_r <= lanes_r;
          end
        end
        default: begin
          cnt_r   <= cnt_r;
          lanes_r <= lanes_r;
        end
      endcase
    end
  end

  assign bus.fifo_pop_req = pop_req_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_data     = lanes_r;
  assign bus.out_count    = out_count_r;

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer
//   Self-checking bench for nibble_packer. An emulated FIFO (queue) feeds the
//   packer; expected words are built arithmetically from the pushed entries
//   (entry i of a word lands at bit 4*i). Works with or without PACKER_FLUSH_EN.
module tb_nibble_packer;
  localparam int WIDTH = 4;
  localparam int LANES = 4;
  localparam int L2L   = 2;
  localparam int FLUSH = 7;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  nibble_packer_if #(.WIDTH(WIDTH), .LANES(LANES), .L2L(L2L)) bus ();

  nibble_packer #(
    .WIDTH(WIDTH), .LANES(LANES), .L2L(L2L), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  fifo_q[$];
  int          ack_rate;
  int          ready_rate;
  bit          force_empty;
  int          cyc = 0;

  bit          seen_req;
  bit          seen_valid;
  bit          seen_pop;
  bit          seen_word;
  logic [15:0] seen_data;
  logic [2:0]  seen_count;

  // Sample one cycle at the falling edge, then drive the next cycle just after the rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    seen_req   = bus.fifo_pop_req;
    seen_valid = bus.out_valid;
    seen_pop   = bus.fifo_pop_req && bus.fifo_pop_ack;
    seen_word  = bus.out_valid && bus.out_ready;
    seen_data  = bus.out_data;
    seen_count = bus.out_count;
    @(posedge clk);
    #1;
    if (seen_pop && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
    else bus.fifo_data = 4'($urandom);
    bus.fifo_pop_ack = (fifo_q.size() > 0) && (int'($urandom_range(99)) < ack_rate);
    bus.fifo_empty   = force_empty || (fifo_q.size() == 0);
    bus.out_ready    = (int'($urandom_range(99)) < ready_rate);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    fifo_q.delete();
    ack_rate = 100; ready_rate = 100; force_empty = 1'b0;
    bus.fifo_pop_ack = 1'b1; bus.fifo_data = 4'hF; bus.fifo_empty = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.fifo_pop_ack = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input int limit, output bit got, output logic [15:0] d, output logic [2:0] c);
    got = 1'b0; d = 16'h0; c = 3'd0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (seen_valid) begin got = 1'b1; d = seen_data; c = seen_count; end
    end
  endtask

  function automatic logic [15:0] pack(input logic [3:0] n0, n1, n2, n3);
    return 16'(n0) + (16'(n1) << 4) + (16'(n2) << 8) + (16'(n3) << 12);
  endfunction

  task automatic test_reset();
    resetn = 1'b1;
    bus.fifo_pop_ack = 1'b1; bus.fifo_data = 4'hF; bus.fifo_empty = 1'b0; bus.out_ready = 1'b1;
    #1 resetn = 1'b0;
    #2;
    n_cmp++; if (bus.fifo_pop_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", bus.fifo_pop_req); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", bus.out_data); end
    n_cmp++; if (bus.out_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.out_count); end
    repeat (2) @(posedge clk);
    #1;
    bus.fifo_pop_ack = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.fifo_pop_req !== 1'b0) begin n_bad++; $display("FAIL req_before_first_edge: got %b expected 0", bus.fifo_pop_req); end
    @(negedge clk);
    n_cmp++; if (bus.fifo_pop_req !== 1'b1) begin n_bad++; $display("FAIL req_after_first_edge: got %b expected 1", bus.fifo_pop_req); end
  endtask

  task automatic test_basic();
    int hs_cyc; int v_cyc;
    apply_reset();
    fifo_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    hs_cyc = -1; v_cyc = -1;
    for (int i = 0; i < 40 && v_cyc < 0; i++) begin
      tick();
      if (seen_pop && hs_cyc < 0) hs_cyc = cyc;
      if (seen_valid) v_cyc = cyc;
    end
    n_cmp++; if (v_cyc < 0 || hs_cyc < 0 || (v_cyc - hs_cyc) != 8) begin n_bad++; $display("FAIL basic_latency: got %0d cycles expected 8", v_cyc - hs_cyc); end
    n_cmp++; if (seen_data !== 16'h4321) begin n_bad++; $display("FAIL basic_data: got %h expected 4321", seen_data); end
    n_cmp++; if (seen_count !== 3'd4) begin n_bad++; $display("FAIL basic_count: got %0d expected 4", seen_count); end
  endtask

  task automatic test_backpressure();
    logic [3:0] n[4]; logic [15:0] w; bit got; logic [15:0] d; logic [2:0] c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom); fifo_q.push_back(n[i]); end
    w = pack(n[0], n[1], n[2], n[3]);
    ready_rate = 0;
    wait_valid(60, got, d, c);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL bp_timeout: got no out_valid expected one within 60 cycles"); end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) tick();
      n_cmp++;
      if (seen_valid !== 1'b1 || seen_req !== 1'b0 || seen_data !== w) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got valid=%b req=%b data=%h expected 1 0 %h", s, seen_valid, seen_req, seen_data, w);
      end
    end
    ready_rate = 100;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (seen_word !== 1'b1 || seen_data !== w) begin n_bad++; $display("FAIL bp_accept: got hs=%b data=%h expected 1 %h", seen_word, seen_data, w); end
    tick();
    n_cmp++; if (seen_req !== 1'b1 || seen_valid !== 1'b0 || seen_data !== 16'h0) begin
      n_bad++; $display("FAIL bp_after: got req=%b valid=%b data=%h expected 1 0 0000", seen_req, seen_valid, seen_data);
    end
  endtask

  task automatic test_ack_stall();
    logic [3:0] n[4]; logic [15:0] w; bit found; bit got; logic [15:0] d; logic [2:0] c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom); fifo_q.push_back(n[i]); end
    w = pack(n[0], n[1], n[2], n[3]);
    ack_rate = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); found = seen_req; end
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      n_cmp++;
      if (seen_req !== 1'b1 || seen_data !== 16'h0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got req=%b data=%h expected 1 0000", s, seen_req, seen_data);
      end
    end
    ack_rate = 100;
    bus.fifo_pop_ack = 1'b1;
    wait_valid(60, got, d, c);
    n_cmp++; if (!got || d !== w || c !== 3'd4) begin n_bad++; $display("FAIL stall_word: got valid=%b data=%h count=%0d expected 1 %h 4", got, d, c, w); end
  endtask

  task automatic test_reset_midword();
    logic [3:0] n[4]; logic [15:0] w; int pops; bit got; logic [15:0] d; logic [2:0] c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom_range(15, 1)); fifo_q.push_back(n[i]); end
    pops = 0;
    for (int i = 0; i < 30 && pops < 2; i++) begin tick(); if (seen_pop) pops++; end
    tick();
    n_cmp++; if (bus.out_data !== pack(n[0], n[1], 4'd0, 4'd0)) begin n_bad++; $display("FAIL midword_partial: got %h expected %h", bus.out_data, pack(n[0], n[1], 4'd0, 4'd0)); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (bus.out_data !== 16'h0 || bus.out_valid !== 1'b0 || bus.fifo_pop_req !== 1'b0 || bus.out_count !== 3'd0) begin
      n_bad++; $display("FAIL midword_reset: got data=%h valid=%b req=%b count=%0d expected 0000 0 0 0", bus.out_data, bus.out_valid, bus.fifo_pop_req, bus.out_count);
    end
    @(posedge clk);
    #1;
    fifo_q.delete();
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom); fifo_q.push_back(n[i]); end
    w = pack(n[0], n[1], n[2], n[3]);
    bus.fifo_pop_ack = 1'b0;
    resetn = 1'b1;
    wait_valid(60, got, d, c);
    n_cmp++; if (!got || d !== w || c !== 3'd4) begin n_bad++; $display("FAIL midword_fresh: got valid=%b data=%h count=%0d expected 1 %h 4", got, d, c, w); end
  endtask

  task automatic test_flush();
    int pops; int req_after; bit got;
    apply_reset();
    fifo_q = '{4'd5, 4'd6};
    pops = 0; req_after = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (seen_valid) got = 1'b1;
      else if (pops == 2 && seen_req) req_after++;
      if (seen_pop) pops++;
    end
`ifdef PACKER_FLUSH_EN
    n_cmp++; if (!got || req_after != FLUSH) begin n_bad++; $display("FAIL flush_timing: got valid=%b empty_cycles=%0d expected 1 %0d", got, req_after, FLUSH); end
    n_cmp++; if (seen_data !== 16'h0065 || seen_count !== 3'd2) begin n_bad++; $display("FAIL flush_word: got data=%h count=%0d expected 0065 2", seen_data, seen_count); end
    tick();
    n_cmp++; if (seen_valid !== 1'b0 || seen_data !== 16'h0) begin n_bad++; $display("FAIL flush_after: got valid=%b data=%h expected 0 0000", seen_valid, seen_data); end
`else
    n_cmp++; if (got) begin n_bad++; $display("FAIL noflush_valid: got out_valid=1 expected 0"); end
    n_cmp++; if (seen_data !== 16'h0065) begin n_bad++; $display("FAIL noflush_hold: got data=%h expected 0065", seen_data); end
`endif
  endtask

  task automatic test_flush_race();
    logic [3:0] n[4]; logic [15:0] w; bit found; int reqs; bit got; logic [15:0] d; logic [2:0] c;
    apply_reset();
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom); fifo_q.push_back(n[i]); end
    w = pack(n[0], n[1], n[2], n[3]);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); found = seen_pop; end
    ack_rate = 0; force_empty = 1'b1;
    reqs = 0;
    for (int i = 0; i < 20 && reqs < FLUSH - 1; i++) begin tick(); if (seen_req) reqs++; end
    bus.fifo_pop_ack = 1'b1;
    tick();
    n_cmp++; if (seen_pop !== 1'b1 || seen_valid !== 1'b0) begin n_bad++; $display("FAIL race_pop: got pop=%b valid=%b expected 1 0", seen_pop, seen_valid); end
    ack_rate = 100; force_empty = 1'b0;
    wait_valid(60, got, d, c);
    n_cmp++; if (!got || d !== w || c !== 3'd4) begin n_bad++; $display("FAIL race_word: got valid=%b data=%h count=%0d expected 1 %h 4", got, d, c, w); end
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$]; logic [15:0] w; logic [3:0] nib;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      ack_rate = int'($urandom_range(100, 30));
      ready_rate = int'($urandom_range(100, 30));
      exp_q.delete();
      for (int k = 0; k < 5; k++) begin
        w = 16'h0;
        for (int i = 0; i < 4; i++) begin
          nib = 4'($urandom);
          fifo_q.push_back(nib);
          w = w + (16'(nib) << (4 * i));
        end
        exp_q.push_back(w);
      end
      for (int t = 0; t < 600 && exp_q.size() > 0; t++) begin
        tick();
        if (seen_word) begin
          w = exp_q.pop_front();
          n_cmp++;
          if (seen_data !== w || seen_count !== 3'd4) begin
            n_bad++; $display("FAIL random_word: got data=%h count=%0d expected %h 4", seen_data, seen_count, w);
          end
        end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL random_missing: got %0d words left expected 0", exp_q.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_stall();
    test_reset_midword();
    test_flush();
    test_flush_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "time limit");
  end
endmodule
